// File: rtl/scs8hd_o221a_bist_ctl_if.sv
// Handshake and observation bundle between the o221a BIST controller and its bench or the cell under test.
// The controller sits on the slave modport, and whoever drives START/ABORT/DUT_X sits on the master modport.
interface scs8hd_o221a_bist_ctl_if #(
    parameter int ERRW = 6
);
    logic            START;
    logic            ABORT;
    logic            DUT_X;
    logic            A1;
    logic            A2;
    logic            B1;
    logic            B2;
    logic            C1;
    logic            BUSY;
    logic            DONE;
    logic            PASS;
    logic [ERRW-1:0] ERRCNT;
    logic [4:0]      FAILVEC;
    logic [15:0]     SIG;

    modport slave (
        input  START, ABORT, DUT_X,
        output A1, A2, B1, B2, C1, BUSY, DONE, PASS, ERRCNT, FAILVEC, SIG
    );

    modport master (
        output START, ABORT, DUT_X,
        input  A1, A2, B1, B2, C1, BUSY, DONE, PASS, ERRCNT, FAILVEC, SIG
    );
endinterface

// File: rtl/scs8hd_o221a_bist_ctl.sv
// Exhaustive self-test sequencer for an o221a cell: walks all 32 input vectors and checks X against the golden function.
// For each run it counts mismatches, latches the first failing vector, and compacts every response into a CRC-16 (0x1021) MISR.
module scs8hd_o221a_bist_ctl #(
    parameter int SETTLE_CYCLES = 2,
    parameter int ERRW          = 6
) (
    input  logic                  CLK,
    input  logic                  RESET,
    scs8hd_o221a_bist_ctl_if.slave bus
);
    typedef enum logic [1:0] {
        ST_IDLE,
        ST_APPLY,
        ST_DONE
    } state_t;

    localparam logic [3:0]      LP_SETTLE  = 4'(SETTLE_CYCLES);
    localparam logic [4:0]      LP_LAST    = 5'd31;
    localparam logic [ERRW-1:0] LP_ERR_ONE = ERRW'(1);

    state_t          r_state;
    logic [4:0]      r_vec;
    logic [3:0]      r_settle;
    logic [4:0]      r_stim;
    logic            r_busy;
    logic            r_done;
    logic            r_pass;
    logic [ERRW-1:0] r_errcnt;
    logic [4:0]      r_failvec;
    logic            r_first_fail;
    logic [15:0]     r_sig;

    logic            w_exp;
    logic            w_sample;
    logic            w_mismatch;
    logic            w_err_sat;
    logic [ERRW-1:0] w_errcnt_next;
    logic [15:0]     w_sig_next;

    assign w_exp         = (r_vec[0] | r_vec[1]) & (r_vec[2] | r_vec[3]) & r_vec[4];
    assign w_sample      = (r_state == ST_APPLY) && (r_settle == LP_SETTLE);
    assign w_mismatch    = (bus.DUT_X != w_exp);
    assign w_err_sat     = &r_errcnt;
    assign w_errcnt_next = (w_mismatch && !w_err_sat) ? (r_errcnt + LP_ERR_ONE) : r_errcnt;
    assign w_sig_next    = {r_sig[14:0], 1'b0} ^ (r_sig[15] ? 16'h1021 : 16'h0000) ^ {15'b0, bus.DUT_X};

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            r_state      <= ST_IDLE;
            r_vec        <= '0;
            r_settle     <= '0;
            r_stim       <= '0;
            r_busy       <= 1'b0;
            r_done       <= 1'b0;
            r_pass       <= 1'b0;
            r_errcnt     <= '0;
            r_failvec    <= '0;
            r_first_fail <= 1'b0;
            r_sig        <= '0;
        end else if (bus.ABORT) begin
            // Results stay visible after an abort so a partial run can still be inspected.
            r_state  <= ST_IDLE;
            r_vec    <= '0;
            r_settle <= '0;
            r_stim   <= '0;
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
            r_pass   <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE, ST_DONE: begin
                    if (bus.START) begin
                        r_state      <= ST_APPLY;
                        r_vec        <= '0;
                        r_settle     <= '0;
                        r_stim       <= '0;
                        r_busy       <= 1'b1;
                        r_done       <= 1'b0;
                        r_pass       <= 1'b0;
                        r_errcnt     <= '0;
                        r_failvec    <= '0;
                        r_first_fail <= 1'b0;
                        r_sig        <= '0;
                    end
                end
                ST_APPLY: begin
                    if (w_sample) begin
                        r_errcnt <= w_errcnt_next;
                        r_sig    <= w_sig_next;
                        if (w_mismatch && !r_first_fail) begin
                            r_failvec    <= r_vec;
                            r_first_fail <= 1'b1;
                        end
                        r_settle <= '0;
                        if (r_vec == LP_LAST) begin
                            r_state <= ST_DONE;
                            r_vec   <= '0;
                            r_stim  <= '0;
                            r_busy  <= 1'b0;
                            r_done  <= 1'b1;
                            r_pass  <= (w_errcnt_next == '0);
                        end else begin
                            r_vec  <= r_vec + 5'd1;
                            r_stim <= r_vec + 5'd1;
                        end
                    end else begin
                        r_settle <= r_settle + 4'd1;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                    r_stim  <= '0;
                    r_busy  <= 1'b0;
                    r_done  <= 1'b0;
                    r_pass  <= 1'b0;
                end
            endcase
        end
    end

    assign bus.A1      = r_stim[0];
    assign bus.A2      = r_stim[1];
    assign bus.B1      = r_stim[2];
    assign bus.B2      = r_stim[3];
    assign bus.C1      = r_stim[4];
    assign bus.BUSY    = r_busy;
    assign bus.DONE    = r_done;
    assign bus.PASS    = r_pass;
    assign bus.ERRCNT  = r_errcnt;
    assign bus.FAILVEC = r_failvec;
    assign bus.SIG     = r_sig;
endmodule

// File: tb/tb_scs8hd_o221a_bist_ctl.sv
// Self-checking bench for the o221a BIST controller: models the cell, predicts each run's results into a scoreboard,
// and compares them when DONE rises, along with cycle-accurate checks of the stimulus, BUSY and DONE.
module tb_scs8hd_o221a_bist_ctl;
    localparam int SETTLE  = 2;
    localparam int VEC_CYC = SETTLE + 1;
    localparam int RUN_CYC = 32 * VEC_CYC;

    typedef struct {
        int          err;
        logic [4:0]  fv;
        logic [15:0] sig;
        logic        pass;
    } exp_t;

    logic CLK;
    logic RESET;
    logic [1:0] mode;  // 0: golden cell, 1: X stuck at 0, 2: X stuck at 1
    int   n_vec;
    int   n_miss;
    exp_t sb[$];

    scs8hd_o221a_bist_ctl_if #(.ERRW(6)) bus ();
    scs8hd_o221a_bist_ctl_if #(.ERRW(3)) bus3 ();

    scs8hd_o221a_bist_ctl #(.SETTLE_CYCLES(SETTLE), .ERRW(6)) u_dut (
        .CLK   (CLK),
        .RESET (RESET),
        .bus   (bus)
    );

    scs8hd_o221a_bist_ctl #(.SETTLE_CYCLES(SETTLE), .ERRW(3)) u_dut3 (
        .CLK   (CLK),
        .RESET (RESET),
        .bus   (bus3)
    );

    assign bus.DUT_X  = (mode == 2'd0) ? ((bus.A1 | bus.A2) & (bus.B1 | bus.B2) & bus.C1) :
                        (mode == 2'd1) ? 1'b0 : 1'b1;
    assign bus3.DUT_X = 1'b1;

    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
        end
    endtask

    function automatic logic [4:0] pins();
        return {bus.C1, bus.B2, bus.B1, bus.A2, bus.A1};
    endfunction

    function automatic exp_t model(input int m, input int maxerr);
        exp_t e;
        logic [4:0] v;
        logic g, x;
        bit ff;
        e.err = 0;
        e.fv  = '0;
        e.sig = '0;
        ff    = 0;
        for (int k = 0; k < 32; k++) begin
            v = 5'(k);
            g = (v[0] | v[1]) & (v[2] | v[3]) & v[4];
            x = (m == 0) ? g : (m == 1) ? 1'b0 : 1'b1;
            if (x != g) begin
                if (e.err < maxerr) e.err++;
                if (!ff) begin
                    ff   = 1;
                    e.fv = v;
                end
            end
            e.sig = {e.sig[14:0], 1'b0} ^ (e.sig[15] ? 16'h1021 : 16'h0000) ^ {15'b0, x};
        end
        e.pass = (e.err == 0);
        return e;
    endfunction

    // Called at the falling edge right after the START edge E0; returns at the falling edge after E0+RUN_CYC.
    task automatic run_body(input int m);
        exp_t e;
        sb.push_back(model(m, 63));
        for (int n = 0; n < RUN_CYC; n++) begin
            check_eq("busy_run", 32'(bus.BUSY), 32'd1);
            check_eq("done_run", 32'(bus.DONE), 32'd0);
            check_eq("stim", 32'(pins()), 32'(n / VEC_CYC));
            @(negedge CLK);
        end
        check_eq("done_end", 32'(bus.DONE), 32'd1);
        check_eq("busy_end", 32'(bus.BUSY), 32'd0);
        check_eq("stim_end", 32'(pins()), 32'd0);
        check_eq("sb_depth", 32'(sb.size()), 32'd1);
        if (sb.size() > 0) begin
            e = sb.pop_front();
            check_eq("errcnt", 32'(bus.ERRCNT), 32'(e.err));
            check_eq("failvec", 32'(bus.FAILVEC), 32'(e.fv));
            check_eq("sig", 32'(bus.SIG), 32'(e.sig));
            check_eq("pass", 32'(bus.PASS), 32'(e.pass));
        end
        $display("run mode=%0d errcnt=%0d failvec=%0d sig=%04h pass=%0b",
                 m, bus.ERRCNT, bus.FAILVEC, bus.SIG, bus.PASS);
    endtask

    task automatic pulse_start();
        @(negedge CLK);
        bus.START = 1'b1;
        @(negedge CLK);
        bus.START = 1'b0;
    endtask

    initial begin
        exp_t e3;
        n_vec      = 0;
        n_miss     = 0;
        mode       = 2'd0;
        RESET      = 1'b1;
        bus.START  = 1'b0;
        bus.ABORT  = 1'b0;
        bus3.START = 1'b0;
        bus3.ABORT = 1'b0;
        repeat (2) @(negedge CLK);
        check_eq("rst_busy", 32'(bus.BUSY), 32'd0);
        check_eq("rst_done", 32'(bus.DONE), 32'd0);
        check_eq("rst_pass", 32'(bus.PASS), 32'd0);
        check_eq("rst_stim", 32'(pins()), 32'd0);
        check_eq("rst_err", 32'(bus.ERRCNT), 32'd0);
        check_eq("rst_sig", 32'(bus.SIG), 32'd0);
        check_eq("rst_busy3", 32'(bus3.BUSY), 32'd0);
        RESET = 1'b0;
        @(negedge CLK);

        // Golden cell, then X stuck at 0.
        mode = 2'd0;
        pulse_start();
        run_body(0);
        mode = 2'd1;
        pulse_start();
        run_body(1);

        // Narrow counter, X stuck at 1: the count must saturate.
        sb.push_back(model(2, 7));
        @(negedge CLK);
        bus3.START = 1'b1;
        @(negedge CLK);
        bus3.START = 1'b0;
        repeat (RUN_CYC - 1) @(negedge CLK);
        check_eq("done3_early", 32'(bus3.DONE), 32'd0);
        @(negedge CLK);
        check_eq("done3", 32'(bus3.DONE), 32'd1);
        check_eq("sb_depth3", 32'(sb.size()), 32'd1);
        if (sb.size() > 0) begin
            e3 = sb.pop_front();
            check_eq("errcnt3", 32'(bus3.ERRCNT), 32'(e3.err));
            check_eq("failvec3", 32'(bus3.FAILVEC), 32'(e3.fv));
            check_eq("sig3", 32'(bus3.SIG), 32'(e3.sig));
            check_eq("pass3", 32'(bus3.PASS), 32'(e3.pass));
        end
        $display("run narrow errcnt=%0d failvec=%0d sig=%04h pass=%0b",
                 bus3.ERRCNT, bus3.FAILVEC, bus3.SIG, bus3.PASS);

        // ABORT together with START at the sample edge of vector 10.
        mode = 2'd0;
        pulse_start();
        repeat (10 * VEC_CYC + SETTLE) @(negedge CLK);
        check_eq("stim_pre_abort", 32'(pins()), 32'd10);
        bus.ABORT = 1'b1;
        bus.START = 1'b1;
        @(negedge CLK);
        check_eq("abort_busy", 32'(bus.BUSY), 32'd0);
        check_eq("abort_done", 32'(bus.DONE), 32'd0);
        check_eq("abort_pass", 32'(bus.PASS), 32'd0);
        check_eq("abort_stim", 32'(pins()), 32'd0);
        check_eq("abort_err", 32'(bus.ERRCNT), 32'd0);
        bus.ABORT = 1'b0;
        @(negedge CLK);
        bus.START = 1'b0;
        $display("abort at vec 10, restart");
        run_body(0);

        // Asynchronous reset in the middle of vector 17.
        pulse_start();
        repeat (17 * VEC_CYC + 1) @(negedge CLK);
        check_eq("stim_pre_rst", 32'(pins()), 32'd17);
        #2 RESET = 1'b1;
        #1;
        check_eq("arst_busy", 32'(bus.BUSY), 32'd0);
        check_eq("arst_stim", 32'(pins()), 32'd0);
        check_eq("arst_sig", 32'(bus.SIG), 32'd0);
        check_eq("arst_err", 32'(bus.ERRCNT), 32'd0);
        @(negedge CLK);
        RESET = 1'b0;
        repeat (4) @(negedge CLK);
        check_eq("idle_busy", 32'(bus.BUSY), 32'd0);
        check_eq("idle_done", 32'(bus.DONE), 32'd0);
        check_eq("idle_stim", 32'(pins()), 32'd0);
        $display("reset at vec 17, restart");
        pulse_start();
        run_body(0);

        // START held through a whole run: ignored while busy, restarts from DONE after one cycle.
        @(negedge CLK);
        bus.START = 1'b1;
        @(negedge CLK);
        run_body(0);
        @(negedge CLK);
        check_eq("rerun_done", 32'(bus.DONE), 32'd0);
        check_eq("rerun_busy", 32'(bus.BUSY), 32'd1);
        check_eq("rerun_stim", 32'(pins()), 32'd0);
        bus.START = 1'b0;
        bus.ABORT = 1'b1;
        @(negedge CLK);
        bus.ABORT = 1'b0;
        check_eq("final_busy", 32'(bus.BUSY), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end
endmodule

// File: doc/scs8hd_o221a_bist_ctl.md
Name: scs8hd_o221a_bist_ctl

Overview:
Self-test controller that sits directly upstream and downstream of an o221a-class cell (X = (A1|A2)&(B1|B2)&C1). It drives all 32 input vectors onto the cell's A1/A2/B1/B2/C1 pins and captures the cell's X output. For each vector it compares X against an internal golden function, counts mismatches, records the first failing vector and compacts all responses into a 16-bit signature. It is used for cell-level silicon and netlist bring-up benches.

Parameters:
SETTLE_CYCLES, 2, cycles each vector is held before X is sampled; legal range 1..15.
ERRW, 6, width of the mismatch counter; the counter saturates at 2^ERRW-1.

Ports:
CLK  input  1  clock; all state updates on rising edge.
RESET  input  1  asynchronous, active-high reset.
START  input  1  level-sampled start request; honoured only in IDLE or DONE.
ABORT  input  1  synchronous abort; returns to IDLE from any state.
DUT_X  input  1  X output of the cell under test.
A1, A2, B1, B2, C1  output  1 each  registered stimulus to the cell under test.
BUSY  output  1  high while in APPLY.
DONE  output  1  high in DONE state.
PASS  output  1  valid when DONE=1; equals (ERRCNT==0).
ERRCNT  output  ERRW  saturating mismatch count.
FAILVEC  output  5  index of first mismatching vector; 0 if none.
SIG  output  16  response signature.

Behaviour:
- Clock and reset: one clock; reset is asynchronous and active-high (ports CLK and RESET).
- Reset values: all outputs 0, state IDLE, vector index 0, settle counter 0, internal first-fail flag clear.
- Vector mapping: vec[4:0] drives A1=vec[0], A2=vec[1], B1=vec[2], B2=vec[3], C1=vec[4].
- Golden function: exp = (vec[0]|vec[1]) & (vec[2]|vec[3]) & vec[4].
- States: IDLE, APPLY, DONE.
- IDLE or DONE with START=1 at edge E0:
  - Enter APPLY; vec=0 and stimulus outputs = 0.
  - Clear ERRCNT, FAILVEC, SIG and the first-fail flag.
  - BUSY=1, DONE=0, PASS=0.
- APPLY:
  - The settle counter counts 0..SETTLE_CYCLES. Each vector is held for SETTLE_CYCLES+1 cycles.
  - Vector k is sampled at edge E0+(k+1)*(SETTLE_CYCLES+1).
  - At the sample edge:
    - If DUT_X != exp, ERRCNT increments, saturating at all-ones.
    - If DUT_X != exp and this is the first mismatch, FAILVEC=k and the first-fail flag is set.
    - SIG updates: SIG_next = ((SIG<<1) ^ (SIG[15] ? 16'h1021 : 0)) ^ {15'b0, DUT_X}.
    - If k<31: vec=k+1 is driven at that same edge and the settle counter resets.
    - If k==31: go to DONE and drive stimulus to 0.
- DONE: BUSY=0, DONE=1, PASS=(final ERRCNT==0). ERRCNT, FAILVEC and SIG hold until the next START or RESET.
- Latency: DONE rises at edge E0+32*(SETTLE_CYCLES+1). This is edge E0+96 at the default setting.
- START while in APPLY: ignored; the run continues unaffected.
- ABORT at an edge:
  - Enter IDLE; stimulus, BUSY, DONE and PASS go to 0.
  - ERRCNT, FAILVEC and SIG hold their partial values.
- ABORT and START at the same edge: ABORT wins, and the block is in IDLE after that edge. START is re-sampled on the following edge.
- RESET mid-run: outputs go to their reset values immediately, without waiting for a clock edge. The block stays in IDLE after RESET deasserts until START.
- DUT_X is sampled directly and has no internal synchronizer. The bench is responsible for meeting setup and hold on DUT_X.

Test Plan:
- Golden o221a model wired to the stimulus and DUT_X, SETTLE_CYCLES=2, START pulsed at E0 -> BUSY high for 96 cycles; DONE=1 at E0+96; PASS=1; ERRCNT=0; FAILVEC=0. SIG matches the bench model of the 0x1021 MISR.
- DUT_X tied 0 -> ERRCNT=9, FAILVEC=21, SIG=16'h0000, PASS=0.
- DUT_X tied 1, ERRW=3 -> ERRCNT saturates at 7; FAILVEC=0; PASS=0.
- Golden model, ABORT asserted at sample edge of vec 10, then START -> IDLE after abort with stimulus=0 and DONE=0. The new run completes with PASS=1 and starts from vec 0.
- RESET asserted mid-cycle during vec 17 -> all outputs 0 without a clock edge. After release the block stays in IDLE until START.
- START held high through an entire run -> ignored while BUSY. A new run begins at the first edge in DONE, so DONE is high for exactly one cycle.
